// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions.
// Holds the sample width, the multiplier pipeline depth, the Q1.15 limits and
// the saturation helper used by the butterfly stage (and other FFT stages).
package fft_pkg;

   localparam int DW      = 16;   // Q1.15 sample width
   localparam int MUL_LAT = 4;    // multi16 operand-to-product latency

   localparam logic [DW-1:0] Q15_MAX = 16'h7FFF;
   localparam logic [DW-1:0] Q15_MIN = 16'h8000;

   // Saturated value plus a flag telling whether clipping happened.
   typedef struct packed {
      logic          sat;
      logic [DW-1:0] val;
   } sat_res_t;

   // Narrow a DW+1 bit two's complement value to DW bits. The value is out of
   // range exactly when the two top bits disagree; the top bit gives the sign.
   function automatic sat_res_t sat_dw(input logic [DW:0] din);
      sat_res_t res;
      if (din[DW] != din[DW-1]) begin
         res.sat = 1'b1;
         res.val = din[DW] ? Q15_MIN : Q15_MAX;
      end else begin
         res.sat = 1'b0;
         res.val = din[DW-1:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/butterfly_r2_if.sv
// Butterfly stage bus.
// master: upstream driver (A operand, multiplier products, overflow clear).
// slave : butterfly_r2 (consumes operands, returns X/Y, frame and overflow status).
interface butterfly_r2_if #(
   parameter int DW = fft_pkg::DW
);

   logic                 in_valid;
   logic signed [DW-1:0] a_re;
   logic signed [DW-1:0] a_im;
   logic signed [DW-1:0] pr_ac;
   logic signed [DW-1:0] pr_bd;
   logic signed [DW-1:0] pr_ad;
   logic signed [DW-1:0] pr_bc;
   logic                 ovf_clr;
   logic                 out_valid;
   logic signed [DW-1:0] x_re;
   logic signed [DW-1:0] x_im;
   logic signed [DW-1:0] y_re;
   logic signed [DW-1:0] y_im;
   logic                 frame_done;
   logic                 ovf;

   modport master (
      output in_valid, a_re, a_im, pr_ac, pr_bd, pr_ad, pr_bc, ovf_clr,
      input  out_valid, x_re, x_im, y_re, y_im, frame_done, ovf
   );

   modport slave (
      input  in_valid, a_re, a_im, pr_ac, pr_bd, pr_ad, pr_bc, ovf_clr,
      output out_valid, x_re, x_im, y_re, y_im, frame_done, ovf
   );

endinterface

// File: rtl/delay_line.sv
// Fixed-depth alignment delay line; shifts every cycle, clears to 0 on reset.
// Ports: clk, rst_n (async, active-low), i_d (W bits in), o_q (i_d delayed D cycles).
module delay_line #(
   parameter int W = 1,
   parameter int D = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_stage [D];

   // Shift register: stage 0 takes the input, every later stage its predecessor.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < D; i++) begin
            r_stage[i] <= '0;
         end
      end else begin
         r_stage[0] <= i_d;
         for (int i = 1; i < D; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign o_q = r_stage[D-1];

endmodule

// File: rtl/butterfly_r2.sv
// Radix-2 DIT butterfly behind four multi16 multipliers.
// Aligns A with the products, forms W*B, outputs X=(A+WB)/2 and Y=(A-WB)/2
// saturated to Q1.15, counts outputs per N-sample frame and keeps a sticky
// overflow flag.
// Ports: clk, rst_n (async, active-low), bus (butterfly_r2_if.slave).
module butterfly_r2
   import fft_pkg::*;
#(
   parameter int N = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   butterfly_r2_if.slave bus
);

   localparam int CW = $clog2(N);
   localparam int LW = 2 * DW + 1;

   // ---------------- A / valid alignment with the multiplier pipeline
   logic [LW-1:0]        w_dl_in;
   logic [LW-1:0]        w_dl_out;
   logic                 w_al_valid;
   logic signed [DW-1:0] w_al_re;
   logic signed [DW-1:0] w_al_im;

   assign w_dl_in = {bus.in_valid, bus.a_re, bus.a_im};

   delay_line #(.W(LW), .D(MUL_LAT)) u_a_delay (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (w_dl_in),
      .o_q   (w_dl_out)
   );

   assign w_al_valid = w_dl_out[LW-1];
   assign w_al_re    = w_dl_out[2*DW-1:DW];
   assign w_al_im    = w_dl_out[DW-1:0];

   // ---------------- stage 1: complex product W*B at full precision
   logic                 r_s1_valid;
   logic signed [DW:0]   r_wr;
   logic signed [DW:0]   r_wi;
   logic signed [DW-1:0] r_s1_are;
   logic signed [DW-1:0] r_s1_aim;

   // Stage-1 register; data only moves on a valid slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_wr       <= '0;
         r_wi       <= '0;
         r_s1_are   <= '0;
         r_s1_aim   <= '0;
      end else begin
         r_s1_valid <= w_al_valid;
         if (w_al_valid) begin
            r_wr     <= {bus.pr_ac[DW-1], bus.pr_ac} - {bus.pr_bd[DW-1], bus.pr_bd};
            r_wi     <= {bus.pr_ad[DW-1], bus.pr_ad} + {bus.pr_bc[DW-1], bus.pr_bc};
            r_s1_are <= w_al_re;
            r_s1_aim <= w_al_im;
         end else begin
            r_wr     <= r_wr;
            r_wi     <= r_wi;
            r_s1_are <= r_s1_are;
            r_s1_aim <= r_s1_aim;
         end
      end
   end

   // ---------------- stage 2: sum/difference, halve, saturate
   logic [DW+1:0] w_sx_re, w_sx_im, w_sy_re, w_sy_im;
   sat_res_t      w_rx_re, w_rx_im, w_ry_re, w_ry_im;
   logic          w_any_sat;

   assign w_sx_re = {{2{r_s1_are[DW-1]}}, r_s1_are} + {r_wr[DW], r_wr};
   assign w_sx_im = {{2{r_s1_aim[DW-1]}}, r_s1_aim} + {r_wi[DW], r_wi};
   assign w_sy_re = {{2{r_s1_are[DW-1]}}, r_s1_are} - {r_wr[DW], r_wr};
   assign w_sy_im = {{2{r_s1_aim[DW-1]}}, r_s1_aim} - {r_wi[DW], r_wi};

   // Dropping the LSB is the arithmetic shift right by one (floor).
   assign w_rx_re = sat_dw(w_sx_re[DW+1:1]);
   assign w_rx_im = sat_dw(w_sx_im[DW+1:1]);
   assign w_ry_re = sat_dw(w_sy_re[DW+1:1]);
   assign w_ry_im = sat_dw(w_sy_im[DW+1:1]);

   assign w_any_sat = r_s1_valid &
                      (w_rx_re.sat | w_rx_im.sat | w_ry_re.sat | w_ry_im.sat);

   logic                 r_out_valid;
   logic                 r_frame_done;
   logic                 r_ovf;
   logic [CW-1:0]        r_cnt;
   logic signed [DW-1:0] r_x_re, r_x_im, r_y_re, r_y_im;

   // Output register, frame counter and frame_done pulse (aligned with out_valid).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_frame_done <= 1'b0;
         r_cnt        <= '0;
         r_x_re       <= '0;
         r_x_im       <= '0;
         r_y_re       <= '0;
         r_y_im       <= '0;
      end else begin
         r_out_valid  <= r_s1_valid;
         r_frame_done <= r_s1_valid && (r_cnt == CW'(N - 1));
         if (r_s1_valid) begin
            // N is a power of two, so the natural wrap restarts the frame.
            r_cnt  <= r_cnt + CW'(1);
            r_x_re <= w_rx_re.val;
            r_x_im <= w_rx_im.val;
            r_y_re <= w_ry_re.val;
            r_y_im <= w_ry_im.val;
         end else begin
            r_cnt  <= r_cnt;
            r_x_re <= r_x_re;
            r_x_im <= r_x_im;
            r_y_re <= r_y_re;
            r_y_im <= r_y_im;
         end
      end
   end

   // Sticky overflow: a saturation in the same cycle as a clear keeps it set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (w_any_sat) begin
         r_ovf <= 1'b1;
      end else if (bus.ovf_clr) begin
         r_ovf <= 1'b0;
      end else begin
         r_ovf <= r_ovf;
      end
   end

   assign bus.out_valid  = r_out_valid;
   assign bus.frame_done = r_frame_done;
   assign bus.ovf        = r_ovf;
   assign bus.x_re       = r_x_re;
   assign bus.x_im       = r_x_im;
   assign bus.y_re       = r_y_re;
   assign bus.y_im       = r_y_im;

endmodule

// File: doc/butterfly_r2.md
# butterfly_r2

Radix-2 decimation-in-time butterfly stage that sits directly downstream of the four `multi16` real multipliers forming the complex twiddle product W·B. It delays the butterfly's A operand to match the multiplier pipeline. It combines the four real products into W·B, then produces X = (A + W·B)/2 and Y = (A − W·B)/2 with saturation. It also counts outputs per FFT frame, so the next stage and the controller see frame boundaries and overflow.

## Interface
- `DW`, 16: data width; Q1.15 two's complement on all data ports.
- `MUL_LAT`, 4: latency of `multi16` in cycles, from operand in to product out.
- `N`, 16: output samples per frame; power of two, at least 2.
- `clk`  in  1  single clock; all registers rising-edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  A operand and the matching multiplier operands are presented this cycle.
- `a_re`, `a_im`  in  DW  butterfly A operand, sampled when `in_valid`=1.
- `pr_ac`, `pr_bd`, `pr_ad`, `pr_bc`  in  DW each  `multi16` outputs for Re(B)·Re(W), Im(B)·Im(W), Re(B)·Im(W), Im(B)·Re(W); valid exactly `MUL_LAT` cycles after the matching `in_valid`.
- `ovf_clr`  in  1  clears `ovf`.
- `out_valid`  out  1  X/Y outputs valid.
- `x_re`, `x_im`, `y_re`, `y_im`  out  DW each  butterfly results.
- `frame_done`  out  1  one-cycle pulse, coincident with the N-th `out_valid` of a frame.
- `ovf`  out  1  sticky: set by any saturation event.

## Operation
- Free-running pipeline with no backpressure. Gaps in `in_valid` propagate as gaps in `out_valid`.
- **A and valid alignment:**
  - `a_re`/`a_im` and `in_valid` pass through a `MUL_LAT`-deep shift register that shifts every cycle.
  - Delayed A is therefore aligned with the `pr_*` products.
- **Stage 1** (cycle `MUL_LAT`+1), registered:
  - wr = pr_ac − pr_bd
  - wi = pr_ad + pr_bc
  - Both are DW+1 bits, full precision, no saturation.
  - Aligned A and valid are registered alongside.
- **Stage 2** (cycle `MUL_LAT`+2), registered:
  - sx = A + w and sy = A − w, each DW+2 bits.
  - Each is arithmetic-shifted right by 1 (truncation toward −∞).
  - Each result is saturated to DW bits: max 32767, min −32768.
- **Overflow:**
  - Any of the four lanes saturating in a valid cycle sets `ovf`.
  - `ovf_clr` clears it. If a saturation and `ovf_clr` occur in the same cycle, set wins.
- **Frame counter:**
  - log2(N) bits; increments on each `out_valid`.
  - `frame_done`=1 when `out_valid`=1 and the count is N−1; the counter then wraps to 0.
- Datapath registers are only updated when the corresponding valid bit is 1. Outputs hold their last value otherwise.

## Timing
- Latency from `in_valid` to `out_valid` is `MUL_LAT`+2 cycles, 6 by default.
- Throughput is one butterfly per cycle.
- **Reset values:**
  - `out_valid`=0, `frame_done`=0, `ovf`=0.
  - `x_re`, `x_im`, `y_re`, `y_im` = 0.
  - Frame counter = 0; all delay-line and stage valid bits = 0.
- **Reset mid-frame:** all in-flight samples are discarded and the counter restarts at 0. The first output after reset is sample 0 of a new frame.
- `frame_done` never asserts without `out_valid`.

## Structure
- Shared package `fft_pkg`:
  - `DW`, `MUL_LAT` constants.
  - Q1.15 min/max constants.
  - A `sat_dw` function: DW+1 bits to DW bits, returning a saturated flag.
- Sub-module `delay_line`, parameterised width and depth, async active-low reset to 0:
  - One instance for {`in_valid`, `a_re`, `a_im`}.
  - This is the reusable piece shared with other stages' alignment needs.

## Test plan
- **Basic butterfly:** A=(8192,0), pr_ac=16384, others 0, one `in_valid` pulse.
  - Response: 6 cycles later `out_valid`=1 for one cycle.
  - x=(12288,0), y=(−4096,0); `ovf`=0.
- **Imaginary path:** A=(0,0), pr_ad=8192, pr_bc=8192.
  - Response: x=(0,8192), y=(0,−8192).
- **Positive saturation:** A=(32767,0), pr_ac=32767, pr_bd=−32768.
  - Response: x_re=32767 (saturated), y_re=−16384.
  - `ovf`=1, holding until an `ovf_clr` pulse; 0 the cycle after.
- **Negative saturation with clear collision:** A=(−32768,0), pr_ac=−32768, pr_bd=32767, with `ovf_clr` asserted in the saturation cycle.
  - Response: x_re=−32768; `ovf` stays 1.
- **Frame counting:** 40 back-to-back samples, then a 3-cycle gap, then 8 more.
  - Response: `frame_done` pulses on output samples 16, 32 and 48 only.
  - `out_valid` shows the same 3-cycle gap.
- **Reset mid-operation:** `rst_n` low for 1 cycle after 10 of 16 samples are in flight.
  - Response: no `out_valid` for those samples.
  - Outputs read 0; the next 16 samples produce exactly one `frame_done`, on the 16th.
